mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/naive_mips_bus_pkg.sv | 27 ++
 rtl/mem_arbiter_if.sv | 21 ++
 rtl/mem_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/naive_mips_bus_pkg.sv
// Shared bus definitions: arbiter states, requester IDs and the latched
// downstream request.
package naive_mips_bus_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    GNT_I  = 3'd1,
    GNT_D  = 3'd2,
    DONE_I = 3'd3,
    DONE_D = 3'd4
  } arb_state_t;

  // Requester IDs, also used as the last-served encoding
  localparam logic REQ_IBUS = 1'b0;
  localparam logic REQ_DBUS = 1'b1;

  // Request captured at grant time and replayed on the downstream port
  typedef struct packed {
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic        wr;
  } mem_req_t;

  localparam logic [31:0] RD_ERR_DATA = 32'hFFFF_FFFF;

endpackage

// File: rtl/mem_arbiter_if.sv
// Generic word bus bundle (requester or downstream side). "stall" is the
// requester stall on the ibus/dbus sides and waitrequest on the memory side.
interface mem_arbiter_if;
  logic [31:0] address;
  logic [3:0]  byteenable;
  logic        read;
  logic        write;
  logic [31:0] wrdata;
  logic [31:0] rddata;
  logic        stall;

  modport master (
    output address, byteenable, read, write, wrdata,
    input  rddata, stall
  );

  modport slave (
    input  address, byteenable, read, write, wrdata,
    output rddata, stall
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester (ibus/dbus) round-robin arbiter onto one shared memory port,
// with registered read data, per-transaction wait timeout and sticky error.
module mem_arbiter
  import naive_mips_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] ibus_address,
  input  logic [3:0]  ibus_byteenable,
  input  logic        ibus_read,
  input  logic        ibus_write,
  input  logic [31:0] ibus_wrdata,
  output logic [31:0] ibus_rddata,
  output logic        ibus_stall,
  input  logic [31:0] dbus_address,
  input  logic [3:0]  dbus_byteenable,
  input  logic        dbus_read,
  input  logic        dbus_write,
  input  logic [31:0] dbus_wrdata,
  output logic [31:0] dbus_rddata,
  output logic        dbus_stall,
  output logic [31:0] mem_address,
  output logic [3:0]  mem_byteenable,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_wrdata,
  input  logic [31:0] mem_rddata,
  input  logic        mem_waitrequest,
  output logic        bus_error,
  input  logic        bus_error_clr
);

  localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT);

  arb_state_t  state_q, state_d;
  mem_req_t    req_q, req_d;
  logic        last_q, last_d;
  logic [31:0] cnt_q, cnt_d;
  logic [31:0] irdata_q, irdata_d;
  logic [31:0] drdata_q, drdata_d;
  logic        err_q, err_d;

  logic i_act, d_act, in_gnt, timeout_hit, pick_d;

  assign i_act  = ibus_read | ibus_write;
  assign d_act  = dbus_read | dbus_write;
  assign in_gnt = (state_q == GNT_I) || (state_q == GNT_D);

  // Timeout fires on the wait cycle that brings the count up to TIMEOUT
  assign timeout_hit = in_gnt && mem_waitrequest && (TIMEOUT != 0) &&
                       ((cnt_q + 32'd1) == TIMEOUT_W);

  // Tie goes to whoever was not served last; otherwise the lone requester
  assign pick_d = (i_act && d_act) ? (last_q == REQ_IBUS) : d_act;

  // Next-state, capture and error logic
  always_comb begin
    state_d  = state_q;
    req_d    = req_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    irdata_d = irdata_q;
    drdata_d = drdata_q;
    err_d    = err_q;

    case (state_q)
      GNT_I, GNT_D: begin
        if (mem_waitrequest) cnt_d = cnt_q + 32'd1;
        if (!mem_waitrequest || timeout_hit) begin
          if (state_q == GNT_I) begin
            if (!req_q.wr) irdata_d = timeout_hit ? RD_ERR_DATA : mem_rddata;
            state_d = DONE_I;
            last_d  = REQ_IBUS;
          end else begin
            if (!req_q.wr) drdata_d = timeout_hit ? RD_ERR_DATA : mem_rddata;
            state_d = DONE_D;
            last_d  = REQ_DBUS;
          end
        end
      end
      default: begin
        // IDLE and DONE_x arbitrate identically, allowing back-to-back grants
        if (i_act || d_act) begin
          cnt_d = '0;
          if (pick_d) begin
            state_d = GNT_D;
            req_d   = '{addr: dbus_address, be: dbus_byteenable,
                        wdata: dbus_wrdata, wr: dbus_write};
          end else begin
            state_d = GNT_I;
            req_d   = '{addr: ibus_address, be: ibus_byteenable,
                        wdata: ibus_wrdata, wr: ibus_write};
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    if (timeout_hit)        err_d = 1'b1;
    else if (bus_error_clr) err_d = 1'b0;
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      req_q    <= '0;
      last_q   <= REQ_IBUS;
      cnt_q    <= '0;
      irdata_q <= '0;
      drdata_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      req_q    <= req_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      irdata_q <= irdata_d;
      drdata_q <= drdata_d;
      err_q    <= err_d;
    end
  end

  // Downstream port only carries the latched request while granted
  assign mem_address    = in_gnt ? req_q.addr  : '0;
  assign mem_byteenable = in_gnt ? req_q.be    : '0;
  assign mem_wrdata     = in_gnt ? req_q.wdata : '0;
  assign mem_read       = in_gnt & ~req_q.wr;
  assign mem_write      = in_gnt &  req_q.wr;

  assign ibus_stall  = i_act && (state_q != DONE_I);
  assign dbus_stall  = d_act && (state_q != DONE_D);
  assign ibus_rddata = irdata_q;
  assign dbus_rddata = drdata_q;
  assign bus_error   = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus random traffic, all checked
// against a phase/owner level model of the arbitration rules.
module tb_mem_arbiter;
  import naive_mips_bus_pkg::*;

  localparam int TO = 8;

  logic clk, rst_n, err, clr;
  mem_arbiter_if ibus_if();
  mem_arbiter_if dbus_if();
  mem_arbiter_if mem_if();

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ibus_address(ibus_if.address), .ibus_byteenable(ibus_if.byteenable),
    .ibus_read(ibus_if.read), .ibus_write(ibus_if.write),
    .ibus_wrdata(ibus_if.wrdata), .ibus_rddata(ibus_if.rddata),
    .ibus_stall(ibus_if.stall),
    .dbus_address(dbus_if.address), .dbus_byteenable(dbus_if.byteenable),
    .dbus_read(dbus_if.read), .dbus_write(dbus_if.write),
    .dbus_wrdata(dbus_if.wrdata), .dbus_rddata(dbus_if.rddata),
    .dbus_stall(dbus_if.stall),
    .mem_address(mem_if.address), .mem_byteenable(mem_if.byteenable),
    .mem_read(mem_if.read), .mem_write(mem_if.write),
    .mem_wrdata(mem_if.wrdata), .mem_rddata(mem_if.rddata),
    .mem_waitrequest(mem_if.stall),
    .bus_error(err), .bus_error_clr(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: phase 0 = free, 1 = transaction on memory port, 2 = just finished.
  // who: 0 = ibus, 1 = dbus.
  int          m_phase, m_who, m_last, m_cnt;
  logic [31:0] m_addr, m_wd, m_ird, m_drd;
  logic [3:0]  m_be;
  logic        m_wr, m_err;

  task automatic mdl_reset();
    m_phase = 0; m_who = 0; m_last = 0; m_cnt = 0;
    m_addr = 0; m_wd = 0; m_ird = 0; m_drd = 0; m_be = 0; m_wr = 0; m_err = 0;
  endtask

  function automatic bit act(input int who);
    return (who == 0) ? (ibus_if.read | ibus_if.write) : (dbus_if.read | dbus_if.write);
  endfunction

  function automatic bit e_stall(input int who);
    return act(who) && !(m_phase == 2 && m_who == who);
  endfunction

  task automatic mdl_edge();
    bit to;
    to = 0;
    if (m_phase == 1) begin
      if (mem_if.stall) begin
        m_cnt++;
        to = (TO != 0) && (m_cnt == TO);
      end
      if (!mem_if.stall || to) begin
        if (!m_wr) begin
          if (m_who == 0) m_ird = to ? 32'hFFFF_FFFF : mem_if.rddata;
          else            m_drd = to ? 32'hFFFF_FFFF : mem_if.rddata;
        end
        m_phase = 2;
        m_last  = m_who;
      end
    end else if (act(0) || act(1)) begin
      m_who = (act(0) && act(1)) ? 1 - m_last : (act(1) ? 1 : 0);
      if (m_who == 0) begin
        m_addr = ibus_if.address; m_be = ibus_if.byteenable;
        m_wd = ibus_if.wrdata; m_wr = ibus_if.write;
      end else begin
        m_addr = dbus_if.address; m_be = dbus_if.byteenable;
        m_wd = dbus_if.wrdata; m_wr = dbus_if.write;
      end
      m_cnt = 0;
      m_phase = 1;
    end else begin
      m_phase = 0;
    end
    if (to) m_err = 1;
    else if (clr) m_err = 0;
  endtask

  task automatic cmp_model();
    bit g;
    g = (m_phase == 1);
    chk("m_istall", 32'(ibus_if.stall), 32'(e_stall(0)));
    chk("m_dstall", 32'(dbus_if.stall), 32'(e_stall(1)));
    chk("m_irdata", ibus_if.rddata, m_ird);
    chk("m_drdata", dbus_if.rddata, m_drd);
    chk("m_mread",  32'(mem_if.read),  32'(g && !m_wr));
    chk("m_mwrite", 32'(mem_if.write), 32'(g && m_wr));
    chk("m_maddr",  mem_if.address, g ? m_addr : 32'h0);
    chk("m_mbe",    32'(mem_if.byteenable), g ? 32'(m_be) : 32'h0);
    chk("m_mwd",    mem_if.wrdata, g ? m_wd : 32'h0);
    chk("m_err",    32'(err), 32'(m_err));
  endtask

  task automatic cyc();
    @(posedge clk);
    mdl_edge();
    #1;
    cmp_model();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    mdl_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic set_req(input int who, input bit rd, input bit wr,
                         input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    if (who == 0) begin
      ibus_if.read = rd; ibus_if.write = wr; ibus_if.address = a;
      ibus_if.byteenable = be; ibus_if.wrdata = wd;
    end else begin
      dbus_if.read = rd; dbus_if.write = wr; dbus_if.address = a;
      dbus_if.byteenable = be; dbus_if.wrdata = wd;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; clr = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    mem_if.rddata = 0; mem_if.stall = 1'b0;
    mdl_reset();

    // Reset state
    #3;
    chk("rst_istall", 32'(ibus_if.stall), 0);
    chk("rst_dstall", 32'(dbus_if.stall), 0);
    chk("rst_irdata", ibus_if.rddata, 0);
    chk("rst_drdata", dbus_if.rddata, 0);
    chk("rst_mread",  32'(mem_if.read), 0);
    chk("rst_err",    32'(err), 0);

    // Minimum-latency ibus read; first grant on first edge after reset
    @(negedge clk);
    rst_n = 1'b1;
    set_req(0, 1, 0, 32'h8000_0000, 4'hF, 0);
    mem_if.rddata = 32'h1234_5678;
    #1;
    chk("lat_c0_stall", 32'(ibus_if.stall), 1);
    cyc();
    chk("lat_c1_mread", 32'(mem_if.read), 1);
    chk("lat_c1_addr",  mem_if.address, 32'h8000_0000);
    chk("lat_c1_stall", 32'(ibus_if.stall), 1);
    cyc();
    chk("lat_c2_rdata", ibus_if.rddata, 32'h1234_5678);
    chk("lat_c2_stall", 32'(ibus_if.stall), 0);
    set_req(0, 0, 0, 0, 0, 0);
    cyc();
    chk("lat_c3_mread", 32'(mem_if.read), 0);

    // Tie after reset: dbus first, then alternating while both hold requests
    do_reset();
    set_req(0, 1, 0, 32'h100, 4'hF, 0);
    set_req(1, 0, 1, 32'h200, 4'b0011, 32'hDEAD_BEEF);
    cyc();
    chk("tie1_mwrite", 32'(mem_if.write), 1);
    chk("tie1_be",     32'(mem_if.byteenable), 32'h3);
    chk("tie1_wd",     mem_if.wrdata, 32'hDEAD_BEEF);
    chk("tie1_addr",   mem_if.address, 32'h200);
    cyc();
    chk("tie1_dstall", 32'(dbus_if.stall), 0);
    chk("tie1_istall", 32'(ibus_if.stall), 1);
    cyc();
    chk("tie2_mread",  32'(mem_if.read), 1);
    chk("tie2_addr",   mem_if.address, 32'h100);
    cyc();
    chk("tie2_istall", 32'(ibus_if.stall), 0);
    cyc();
    chk("tie3_mwrite", 32'(mem_if.write), 1);
    cyc();
    set_req(0, 0, 0, 0, 0, 0);
    set_req(1, 0, 0, 0, 0, 0);
    cyc();

    // Four wait cycles: address stable, completion one cycle after release
    set_req(0, 1, 0, 32'h300, 4'hF, 0);
    mem_if.stall = 1'b1;
    mem_if.rddata = 32'hA5A5_0001;
    cyc();
    for (int k = 0; k < 4; k++) begin
      chk("ws_stall", 32'(ibus_if.stall), 1);
      chk("ws_addr",  mem_if.address, 32'h300);
      cyc();
    end
    mem_if.stall = 1'b0;
    #1;
    chk("ws_c5_stall", 32'(ibus_if.stall), 1);
    cyc();
    chk("ws_c6_stall", 32'(ibus_if.stall), 0);
    chk("ws_c6_rdata", ibus_if.rddata, 32'hA5A5_0001);
    set_req(0, 0, 0, 0, 0, 0);
    cyc();

    // Timeout on dbus read, sticky error, then clear
    set_req(1, 1, 0, 32'h400, 4'hF, 0);
    mem_if.stall = 1'b1;
    cyc();
    for (int k = 0; k < TO; k++) begin
      chk("to_stall", 32'(dbus_if.stall), 1);
      chk("to_err0",  32'(err), 0);
      cyc();
    end
    chk("to_done_stall", 32'(dbus_if.stall), 0);
    chk("to_rdata",      dbus_if.rddata, 32'hFFFF_FFFF);
    chk("to_err1",       32'(err), 1);
    set_req(1, 0, 0, 0, 0, 0);
    mem_if.stall = 1'b0;
    cyc();
    chk("to_sticky", 32'(err), 1);
    clr = 1'b1;
    cyc();
    clr = 1'b0;
    chk("to_clr", 32'(err), 0);

    // Asynchronous reset during GNT_D
    set_req(1, 0, 1, 32'h500, 4'hF, 32'h0BAD_F00D);
    mem_if.stall = 1'b1;
    cyc();
    chk("ar_mwrite1", 32'(mem_if.write), 1);
    #2;
    rst_n = 1'b0;
    mdl_reset();
    #1;
    chk("ar_mwrite0", 32'(mem_if.write), 0);
    chk("ar_maddr0",  mem_if.address, 0);
    chk("ar_state",   32'(dut.state_q), 32'(IDLE));
    chk("ar_dstall",  32'(dbus_if.stall), 1);
    @(negedge clk);
    rst_n = 1'b1;
    set_req(1, 0, 0, 0, 0, 0);
    set_req(0, 1, 0, 32'h600, 4'hF, 0);
    mem_if.stall = 1'b0;
    cyc();
    chk("ar_regrant", 32'(mem_if.read), 1);
    chk("ar_raddr",   mem_if.address, 32'h600);
    cyc();
    // Back-to-back ibus reads: new grant straight out of DONE_I
    for (int k = 1; k <= 3; k++) begin
      set_req(0, 1, 0, 32'h600 + 32'(k * 4), 4'hF, 0);
      mem_if.rddata = 32'hC000_0000 + 32'(k);
      cyc();
      chk("b2b_mread", 32'(mem_if.read), 1);
      chk("b2b_addr",  mem_if.address, 32'h600 + 32'(k * 4));
      cyc();
      chk("b2b_rdata", ibus_if.rddata, 32'hC000_0000 + 32'(k));
    end
    set_req(0, 0, 0, 0, 0, 0);
    cyc();

    // Random traffic against the model
    for (int n = 0; n < 600; n++) begin
      for (int w = 0; w < 2; w++) begin
        if (act(w) && e_stall(w)) begin
          if ($urandom_range(0, 31) == 0) set_req(w, 0, 0, 0, 0, 0);
        end else if ($urandom_range(0, 1) == 1) begin
          set_req(w, 1'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom);
        end else begin
          set_req(w, 0, 0, 0, 0, 0);
        end
      end
      mem_if.stall  = ($urandom_range(0, 3) != 0);
      mem_if.rddata = $urandom;
      clr           = ($urandom_range(0, 7) == 0);
      cyc();
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
